layer4_svm_mac_sched: RTL and testbench
=======================================

Name: layer4_svm_mac_sched

Overview:
- Sequencer for the Layer-4 SVM classifier. It time-shares one external 14x16 signed multiplier (30-bit product) to compute NUM_CLASS dot products of a feature vector against per-class weight rows, each followed by a bias term.
- It outputs each class score, then the argmax class.
- It sits between the Layer-3 feature buffer / SVM weight ROM and the classification result interface, using an HLS-style block-level start/done handshake.

Parameters:
- VEC_LEN, 64, features per vector (>=2).
- NUM_CLASS, 10, number of classes (>=2).
- FADDR_W, 6, feature address width, >= clog2(VEC_LEN).
- WADDR_W, 10, weight address width, >= clog2(NUM_CLASS*(VEC_LEN+1)).
- CLS_W, 4, class index width, >= clog2(NUM_CLASS).
- ACC_W, 40, accumulator/score width.

Ports:
- ap_clk  in  1  clock; all logic rising-edge.
- ap_rst  in  1  reset; asynchronous, active-high.
- ap_start  in  1  start request; sampled only while idle.
- ap_done  out  1  one-cycle pulse when the result is valid.
- ap_idle  out  1  high while no run is in progress.
- ap_ready  out  1  one-cycle pulse, same cycle as ap_done.
- feat_addr  out  FADDR_W  feature memory address.
- feat_ce  out  1  feature memory read enable.
- feat_q  in  14  feature read data, signed; valid 1 cycle after ce.
- w_addr  out  WADDR_W  weight memory address.
- w_ce  out  1  weight memory read enable.
- w_q  in  16  weight read data, signed; valid 1 cycle after ce.
- mul_a  out  14  multiplier operand A, registered.
- mul_b  out  16  multiplier operand B, registered.
- mul_p  in  30  combinational product of mul_a*mul_b, signed.
- score  out  ACC_W  class score, signed, registered.
- score_cls  out  CLS_W  class index of score.
- score_vld  out  1  one-cycle pulse per class score.
- result_cls  out  CLS_W  argmax class, held until next run.

Behaviour:
- Reset: every output and all internal state go to 0, except ap_idle=1. Reset mid-run aborts immediately: no ap_done and no further score_vld.
- States:
  - IDLE -> ISSUE on ap_start=1.
  - ISSUE -> DRAIN after the last issue item.
  - DRAIN -> DONE after 3 cycles.
  - DONE -> IDLE after 1 cycle.
- ap_idle=1 only in IDLE. ap_start is ignored outside IDLE.
- Issue order, one item per cycle with no bubbles, for class c=0..NUM_CLASS-1:
  - Items i=0..VEC_LEN-1: feat_ce=w_ce=1, feat_addr=i, w_addr=c*(VEC_LEN+1)+i.
  - Bias item: w_ce=1, feat_ce=0, w_addr=c*(VEC_LEN+1)+VEC_LEN.
  - Total issue cycles: NUM_CLASS*(VEC_LEN+1). Outside ISSUE, ce=0 and addresses hold.
- Pipeline, with the item issued in cycle t:
  - End of t+1: mul_a<=feat_q and mul_b<=w_q. For a bias item, mul_a<=14'sd1, so mul_p equals the bias.
  - End of t+2: accumulate sext(mul_p). acc<=sext(mul_p) on the class's first item, else acc<=acc+sext(mul_p).
  - A 2-stage tag pipeline (valid, first, last, class) travels with each item.
- Score:
  - At end of the bias item's accumulate cycle, score<=final acc and score_cls<=c; score_vld=1 in the following cycle.
  - Class c's score_vld occurs at cycle start+(c+1)*(VEC_LEN+1)+2, counting the first issue cycle as start+0. Back-to-back classes overlap with no stall.
- Arithmetic: two's-complement wrap in ACC_W, no saturation. The defaults cannot overflow.
- Argmax: score_vld for class 0 loads best=score. Later classes replace best only if strictly greater, so ties keep the lower index.
  - result_cls is updated the cycle after the last score_vld, the same cycle ap_done=ap_ready=1 (DONE state).
  - result_cls holds through IDLE and reset-free restarts until overwritten.
- mul_a/mul_b hold their last value when no item is in flight.

Test Plan:
- Reset then idle (VEC_LEN=4, NUM_CLASS=3): ap_idle=1, all other outputs 0, no ce asserted.
- Basic run: features {1,2,3,4}; rows class0 {1,1,1,1,b=0}, class1 {2,0,0,0,b=5}, class2 {-1,-1,-1,-1,b=100}.
  - Scores must be 10, 7, 90.
  - score_vld at cycles 7, 12, 17 after the first issue.
  - result_cls=2 and ap_done at cycle 18.
- Extremes: all features -8192, all weights -32768, VEC_LEN=64, bias 32767.
  - score = 64*268435456+32767 = 17179901951, with no wrap in 40 bits.
- Tie: two classes score 50, the others lower -> result_cls is the lower index.
- ap_start held high for the whole run plus a pulse mid-run -> exactly one run, and ap_idle drops for its full duration. A second run starts only when ap_start is high in IDLE.
- Reset asserted mid-ISSUE at class 1 -> outputs go to 0 asynchronously and ap_idle=1. A restart then gives correct scores, with no stale accumulator carry-over.

Source files
------------

// File: rtl/layer4_svm_mac_sched.sv
// rtl/layer4_svm_mac_sched.sv - Layer-4 SVM multiply-accumulate sequencer with argmax
// Shares one external 14x16 multiplier across NUM_CLASS dot products, each closed by a bias term.
module layer4_svm_mac_sched #(
  parameter int VEC_LEN   = 64,
  parameter int NUM_CLASS = 10,
  parameter int FADDR_W   = 6,
  parameter int WADDR_W   = 10,
  parameter int CLS_W     = 4,
  parameter int ACC_W     = 40
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               ap_start,
  output logic               ap_done,
  output logic               ap_idle,
  output logic               ap_ready,
  output logic [FADDR_W-1:0] feat_addr,
  output logic               feat_ce,
  input  logic [13:0]        feat_q,
  output logic [WADDR_W-1:0] w_addr,
  output logic               w_ce,
  input  logic [15:0]        w_q,
  output logic [13:0]        mul_a,
  output logic [15:0]        mul_b,
  input  logic [29:0]        mul_p,
  output logic [ACC_W-1:0]   score,
  output logic [CLS_W-1:0]   score_cls,
  output logic               score_vld,
  output logic [CLS_W-1:0]   result_cls
);

  localparam int IDX_W = $clog2(VEC_LEN + 1);
  localparam logic [IDX_W-1:0] IDX_BIAS  = IDX_W'(VEC_LEN);
  localparam logic [IDX_W-1:0] IDX_LASTF = IDX_W'(VEC_LEN - 1);
  localparam logic [CLS_W-1:0] CLS_LAST  = CLS_W'(NUM_CLASS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         drain_q, drain_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CLS_W-1:0]   cls_q, cls_d;
  logic [FADDR_W-1:0] faddr_q, faddr_d;
  logic [WADDR_W-1:0] waddr_q, waddr_d;
  logic               fce_q, fce_d;
  logic               wce_q, wce_d;
  logic               last_item;

  logic               t1_vld_q, t1_first_q, t1_last_q;
  logic [CLS_W-1:0]   t1_cls_q;
  logic               t2_vld_q, t2_first_q, t2_last_q;
  logic [CLS_W-1:0]   t2_cls_q;
  logic [13:0]        mul_a_q;
  logic [15:0]        mul_b_q;
  logic [ACC_W-1:0]   acc_q, acc_sum;
  logic [ACC_W-1:0]   score_q;
  logic [CLS_W-1:0]   score_cls_q;
  logic               score_vld_q;
  logic [ACC_W-1:0]   best_q;
  logic [CLS_W-1:0]   best_cls_q;
  logic [CLS_W-1:0]   result_cls_q;
  logic               take_new;

  // idx_q/cls_q name the item being issued in the current ISSUE cycle
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    idx_d     = idx_q;
    cls_d     = cls_q;
    faddr_d   = faddr_q;
    waddr_d   = waddr_q;
    fce_d     = 1'b0;
    wce_d     = 1'b0;
    last_item = (idx_q == IDX_BIAS) && (cls_q == CLS_LAST);
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          state_d = S_ISSUE;
          idx_d   = '0;
          cls_d   = '0;
          faddr_d = '0;
          waddr_d = '0;
          fce_d   = 1'b1;
          wce_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        if (last_item) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          wce_d   = 1'b1;
          waddr_d = waddr_q + 1'b1;
          if (idx_q == IDX_BIAS) begin
            idx_d   = '0;
            cls_d   = cls_q + 1'b1;
            faddr_d = '0;
            fce_d   = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            if (idx_q != IDX_LASTF) begin
              fce_d   = 1'b1;
              faddr_d = FADDR_W'(idx_q + 1'b1);
            end
          end
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == 2'd2) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      idx_q   <= '0;
      cls_q   <= '0;
      faddr_q <= '0;
      waddr_q <= '0;
      fce_q   <= 1'b0;
      wce_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      idx_q   <= idx_d;
      cls_q   <= cls_d;
      faddr_q <= faddr_d;
      waddr_q <= waddr_d;
      fce_q   <= fce_d;
      wce_q   <= wce_d;
    end
  end

  // The first item of a class restarts the sum, so no clear cycle is needed between classes
  always_comb begin
    acc_sum = (t2_first_q ? '0 : acc_q) + {{(ACC_W-30){mul_p[29]}}, mul_p};
  end

  // Class 0 always seeds the running best; later classes need a strictly larger score
  always_comb begin
    take_new = (score_cls_q == '0) || ($signed(score_q) > $signed(best_q));
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      t1_vld_q     <= 1'b0;
      t1_first_q   <= 1'b0;
      t1_last_q    <= 1'b0;
      t1_cls_q     <= '0;
      t2_vld_q     <= 1'b0;
      t2_first_q   <= 1'b0;
      t2_last_q    <= 1'b0;
      t2_cls_q     <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      acc_q        <= '0;
      score_q      <= '0;
      score_cls_q  <= '0;
      score_vld_q  <= 1'b0;
      best_q       <= '0;
      best_cls_q   <= '0;
      result_cls_q <= '0;
    end else begin
      t1_vld_q   <= (state_q == S_ISSUE);
      t1_first_q <= (idx_q == '0);
      t1_last_q  <= (idx_q == IDX_BIAS);
      t1_cls_q   <= cls_q;
      t2_vld_q   <= t1_vld_q;
      t2_first_q <= t1_first_q;
      t2_last_q  <= t1_last_q;
      t2_cls_q   <= t1_cls_q;
      if (t1_vld_q) begin
        mul_a_q <= t1_last_q ? 14'sd1 : feat_q;
        mul_b_q <= w_q;
      end
      if (t2_vld_q) acc_q <= acc_sum;
      score_vld_q <= t2_vld_q && t2_last_q;
      if (t2_vld_q && t2_last_q) begin
        score_q     <= acc_sum;
        score_cls_q <= t2_cls_q;
      end
      if (score_vld_q && take_new) begin
        best_q     <= score_q;
        best_cls_q <= score_cls_q;
      end
      if (score_vld_q && (score_cls_q == CLS_LAST)) begin
        result_cls_q <= take_new ? score_cls_q : best_cls_q;
      end
    end
  end

  assign ap_idle    = (state_q == S_IDLE);
  assign ap_done    = (state_q == S_DONE);
  assign ap_ready   = (state_q == S_DONE);
  assign feat_addr  = faddr_q;
  assign feat_ce    = fce_q;
  assign w_addr     = waddr_q;
  assign w_ce       = wce_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign score      = score_q;
  assign score_cls  = score_cls_q;
  assign score_vld  = score_vld_q;
  assign result_cls = result_cls_q;

endmodule

// File: tb/tb_layer4_svm_mac_sched.sv
// tb/tb_layer4_svm_mac_sched.sv - directed self-checking bench for layer4_svm_mac_sched
// Instance a: VEC_LEN=4, NUM_CLASS=3; instance b: VEC_LEN=64, NUM_CLASS=2 for the extreme-value run.
module tb_layer4_svm_mac_sched;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  logic               a_start = 1'b0;
  logic               a_done, a_idle, a_ready, a_fce, a_wce, a_vld;
  logic [5:0]         a_faddr;
  logic [9:0]         a_waddr;
  logic signed [13:0] a_fq, a_mula;
  logic signed [15:0] a_wq, a_mulb;
  logic signed [29:0] a_mulp;
  logic signed [39:0] a_score;
  logic [3:0]         a_scls, a_rcls;
  logic signed [13:0] a_fmem [0:63];
  logic signed [15:0] a_wmem [0:1023];

  logic               b_start = 1'b0;
  logic               b_done, b_idle, b_ready, b_fce, b_wce, b_vld;
  logic [5:0]         b_faddr;
  logic [9:0]         b_waddr;
  logic signed [13:0] b_fq, b_mula;
  logic signed [15:0] b_wq, b_mulb;
  logic signed [29:0] b_mulp;
  logic signed [39:0] b_score;
  logic [3:0]         b_scls, b_rcls;
  logic signed [13:0] b_fmem [0:63];
  logic signed [15:0] b_wmem [0:1023];

  always @(posedge ap_clk) begin
    if (a_fce) a_fq <= a_fmem[a_faddr];
    if (a_wce) a_wq <= a_wmem[a_waddr];
    if (b_fce) b_fq <= b_fmem[b_faddr];
    if (b_wce) b_wq <= b_wmem[b_waddr];
  end
  assign a_mulp = a_mula * a_mulb;
  assign b_mulp = b_mula * b_mulb;

  layer4_svm_mac_sched #(.VEC_LEN(4), .NUM_CLASS(3), .FADDR_W(6), .WADDR_W(10), .CLS_W(4), .ACC_W(40)) u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(a_start), .ap_done(a_done), .ap_idle(a_idle),
    .ap_ready(a_ready), .feat_addr(a_faddr), .feat_ce(a_fce), .feat_q(a_fq), .w_addr(a_waddr),
    .w_ce(a_wce), .w_q(a_wq), .mul_a(a_mula), .mul_b(a_mulb), .mul_p(a_mulp), .score(a_score),
    .score_cls(a_scls), .score_vld(a_vld), .result_cls(a_rcls)
  );

  layer4_svm_mac_sched #(.VEC_LEN(64), .NUM_CLASS(2), .FADDR_W(6), .WADDR_W(10), .CLS_W(4), .ACC_W(40)) u_dut64 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(b_start), .ap_done(b_done), .ap_idle(b_idle),
    .ap_ready(b_ready), .feat_addr(b_faddr), .feat_ce(b_fce), .feat_q(b_fq), .w_addr(b_waddr),
    .w_ce(b_wce), .w_q(b_wq), .mul_a(b_mula), .mul_b(b_mulb), .mul_p(b_mulp), .score(b_score),
    .score_cls(b_scls), .score_vld(b_vld), .result_cls(b_rcls)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc = 0, t0 = 0, tb0 = 0;
  int     nv, done_n, done_rel, busy_n, wce_n, fce_n, wsum, fsum;
  longint sv [4];
  int     sc [4], sr [4];
  logic   done_rdy;
  logic [3:0] done_cls;
  int     bn, b_done_n;
  longint bsv [2];
  int     brel [2], bcls [2];
  logic   b_rdy;
  logic [3:0] b_cls;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Advance to the next falling edge and record everything observable there
  task automatic tick();
    @(negedge ap_clk);
    cyc++;
    if (a_vld) begin
      if (nv < 4) begin
        sv[nv] = longint'(a_score);
        sc[nv] = int'(a_scls);
        sr[nv] = cyc - t0;
      end
      nv++;
    end
    if (a_done) begin
      done_n++;
      done_rel = cyc - t0;
      done_rdy = a_ready;
      done_cls = a_rcls;
    end
    if (!a_idle) busy_n++;
    if (a_wce) begin wce_n++; wsum += int'(a_waddr); end
    if (a_fce) begin fce_n++; fsum += int'(a_faddr); end
    if (b_vld) begin
      if (bn < 2) begin
        bsv[bn]  = longint'(b_score);
        brel[bn] = cyc - tb0;
        bcls[bn] = int'(b_scls);
      end
      bn++;
    end
    if (b_done) begin b_done_n++; b_cls = b_rcls; b_rdy = b_ready; end
  endtask

  task automatic clear_mon();
    nv = 0; done_n = 0; done_rel = -1; busy_n = 0;
    wce_n = 0; fce_n = 0; wsum = 0; fsum = 0;
    done_rdy = 1'b0; done_cls = '0;
  endtask

  task automatic chk_reset(input string nm);
    check({nm, "_idle"}, a_idle, 1);
    check({nm, "_ctl"}, {a_done, a_ready, a_fce, a_wce, a_vld, a_faddr, a_waddr, a_scls, a_rcls}, 0);
    check({nm, "_mul"}, {a_mula, a_mulb}, 0);
    check({nm, "_score"}, a_score, 0);
  endtask

  task automatic set_feat(input int f0, input int f1, input int f2, input int f3);
    a_fmem[0] = 14'(f0); a_fmem[1] = 14'(f1); a_fmem[2] = 14'(f2); a_fmem[3] = 14'(f3);
  endtask

  task automatic set_row(input int c, input int w0, input int w1, input int w2, input int w3, input int b);
    a_wmem[c*5+0] = 16'(w0); a_wmem[c*5+1] = 16'(w1); a_wmem[c*5+2] = 16'(w2);
    a_wmem[c*5+3] = 16'(w3); a_wmem[c*5+4] = 16'(b);
  endtask

  task automatic load_basic();
    set_feat(1, 2, 3, 4);
    set_row(0, 1, 1, 1, 1, 0);
    set_row(1, 2, 0, 0, 0, 5);
    set_row(2, -1, -1, -1, -1, 100);
  endtask

  task automatic run_a(input string nm, input bit hold, input int pulse_at,
                       input longint e0, input longint e1, input longint e2, input int ecls);
    longint ex [3];
    ex[0] = e0; ex[1] = e1; ex[2] = e2;
    clear_mon();
    a_start = 1'b1;
    t0 = cyc + 1;
    for (int k = 0; k < 60 && done_n == 0; k++) begin
      tick();
      a_start = hold || (k + 1 == pulse_at);
    end
    a_start = 1'b0;
    repeat (6) tick();
    check({nm, "_nvld"}, nv, 3);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("%s_score%0d", nm, c), sv[c], ex[c]);
      check($sformatf("%s_cls%0d", nm, c), sc[c], c);
      check($sformatf("%s_vldcyc%0d", nm, c), sr[c], (c + 1) * 5 + 2);
    end
    check({nm, "_done_n"}, done_n, 1);
    check({nm, "_done_cyc"}, done_rel, 18);
    check({nm, "_ready"}, done_rdy, 1);
    check({nm, "_result_at_done"}, done_cls, ecls);
    check({nm, "_busy"}, busy_n, 19);
    check({nm, "_wce_n"}, wce_n, 15);
    check({nm, "_fce_n"}, fce_n, 12);
    check({nm, "_wsum"}, wsum, 105);
    check({nm, "_fsum"}, fsum, 18);
    check({nm, "_idle_after"}, a_idle, 1);
    check({nm, "_result_held"}, a_rcls, ecls);
  endtask

  initial begin
    clear_mon();
    bn = 0; b_done_n = 0; b_rdy = 1'b0; b_cls = '0;
    load_basic();
    for (int i = 0; i < 64; i++) b_fmem[i] = -14'sd8192;
    for (int i = 0; i < 64; i++) b_wmem[i] = -16'sd32768;
    b_wmem[64] = 16'sd32767;
    for (int i = 65; i < 130; i++) b_wmem[i] = 16'sd0;

    tick();
    chk_reset("reset");
    ap_rst = 1'b0;
    repeat (3) tick();
    chk_reset("post_reset");

    run_a("basic", 1'b0, 0, 10, 7, 90, 2);

    set_feat(1, 1, 1, 1);
    set_row(0, 1, 1, 1, 1, 16);
    set_row(1, 10, 0, 0, 0, 40);
    set_row(2, 5, 5, 5, 5, 30);
    run_a("tie", 1'b0, 0, 20, 50, 50, 1);

    set_feat(1, 2, 3, 4);
    set_row(0, 0, 0, 0, 0, -100);
    set_row(1, -1, 0, 0, 0, -4);
    set_row(2, 0, 0, 0, -10, -10);
    run_a("neg", 1'b0, 0, -100, -5, -50, 1);

    load_basic();
    run_a("held", 1'b1, 0, 10, 7, 90, 2);
    run_a("pulse", 1'b0, 8, 10, 7, 90, 2);

    bn = 0; b_done_n = 0;
    b_start = 1'b1;
    tb0 = cyc + 1;
    tick();
    b_start = 1'b0;
    for (int k = 0; k < 200 && b_done_n == 0; k++) tick();
    repeat (3) tick();
    check("ext_nvld", bn, 2);
    check("ext_score0", bsv[0], 64'sd17179901951);
    check("ext_score1", bsv[1], 0);
    check("ext_cls1", bcls[1], 1);
    check("ext_vldcyc0", brel[0], 67);
    check("ext_vldcyc1", brel[1], 132);
    check("ext_done_n", b_done_n, 1);
    check("ext_ready", b_rdy, 1);
    check("ext_result", b_cls, 0);
    check("ext_idle", b_idle, 1);

    clear_mon();
    a_start = 1'b1;
    t0 = cyc + 1;
    tick();
    a_start = 1'b0;
    while (cyc - t0 < 7) tick();
    check("mid_vld0", nv, 1);
    check("mid_busy", a_idle, 0);
    ap_rst = 1'b1;
    #1;
    chk_reset("mid_rst");
    repeat (3) tick();
    ap_rst = 1'b0;
    repeat (25) tick();
    check("mid_no_more_vld", nv, 1);
    check("mid_no_done", done_n, 0);
    check("mid_idle", a_idle, 1);

    run_a("restart", 1'b0, 0, 10, 7, 90, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
